pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Registered control unit for the 5-stage RV32I pipeline; successor to the flat opcode decoder.
//  Decodes the ID-stage opcode into a control bundle and registers it into the ID/EX stage.
//  Detects load-use hazards (stall), applies branch flushes (bubble) and runs the HALT drain FSM.
//  Drives PC/IF-ID write enables and a sticky halted flag to the core top level.
// PARAMETERS
//  REG_ADDR_W   5  register-index width (rs1/rs2/rd)
//  DRAIN_DEPTH  3  cycles after HALT leaves ID before halted_o asserts (>=1)
// PORTS
//  clk            in   1           core clock, all state updates on posedge
//  reset          in   1           asynchronous, active-high; clears all state immediately
//  opcode_i       in   7           instr[6:0] of the IF/ID register
//  rs1_i          in   REG_ADDR_W  instr[19:15] of the IF/ID register
//  rs2_i          in   REG_ADDR_W  instr[24:20] of the IF/ID register
//  ex_rd_i        in   REG_ADDR_W  rd held in ID/EX
//  ex_memread_i   in   1           MemRead held in ID/EX (the load in EX)
//  branch_taken_i in   1           EX-stage branch resolved taken this cycle
//  ex_alusrc_o    out  1           registered ALUSrc (1: immediate operand)
//  ex_memtoreg_o  out  1           registered MemtoReg (1: writeback from memory)
//  ex_regwrite_o  out  1           registered RegWrite
//  ex_memread_o   out  1           registered MemRead
//  ex_memwrite_o  out  1           registered MemWrite
//  ex_aluop_o     out  2           registered ALUOp (00 LW/SW, 01 branch, 10 R/I-type)
//  ex_branch_o    out  1           registered Branch
//  ex_jump_o      out  1           registered Jump (tied 0 unless CTRL_JUMP_EN)
//  pc_write_o     out  1           comb.; 0 freezes PC
//  ifid_write_o   out  1           comb.; 0 holds the IF/ID register
//  ifid_flush_o   out  1           comb.; 1 clears the IF/ID register
//  illegal_o      out  1           registered 1-cycle pulse: unknown opcode reached EX as a bubble
//  halted_o       out  1           registered, sticky until reset
// BEHAVIOUR
//  Reset: all ex_*_o=0, illegal_o=0, halted_o=0, state=RUN, drain counter=0.
//   pc_write_o, ifid_write_o and ifid_flush_o are 0 while reset is high.
//  Decode: R 0110011, LW 0000011, SW 0100011, BR 1100011, IMM 0010011, HALT 1110101.
//   ALUSrc=LW|SW|IMM; MemtoReg=MemRead=LW; MemWrite=SW; RegWrite=R|LW|IMM only;
//   ALUOp[0]=BR; ALUOp[1]=R|IMM; Branch=BR. HALT and unknown opcodes decode to all-zero.
//  Latency: the bundle decoded in cycle N appears on ex_*_o after posedge N+1.
//  Load-use stall: ex_memread_i & ex_rd_i!=0 & (ex_rd_i==rs1_i | (uses_rs2 & ex_rd_i==rs2_i)).
//   uses_rs1 covers R/LW/SW/BR/IMM; uses_rs2 covers R/SW/BR.
//   Stall => pc_write_o=0, ifid_write_o=0, bubble (all-zero bundle) into ID/EX. Lasts exactly 1 cycle.
//  Flush: branch_taken_i => ifid_flush_o=1, bubble into ID/EX, pc_write_o=1.
//   Flush beats stall; a HALT in ID during a flush is wrong-path and is discarded.
//  FSM RUN/DRAIN/HALTED:
//   RUN->DRAIN when HALT is in ID with no flush: pc_write_o=ifid_write_o=0, counter=DRAIN_DEPTH-1.
//   DRAIN: bubbles only; PC/IF-ID frozen; counter decrements each cycle; at 0 -> HALTED.
//    branch_taken_i is ignored in DRAIN, since no branch can be older than the HALT.
//   HALTED: halted_o=1, bubbles, PC/IF-ID frozen; left only via reset.
//   Reset mid-DRAIN returns to RUN with counter=0 and no halted pulse.
//  Counter width $clog2(DRAIN_DEPTH+1); it never wraps (it saturates at 0).
//  illegal_o: pulses for 1 cycle, 1 cycle after an unknown opcode is in ID in RUN (no stall/flush).
// CONFIGURATION
//  CTRL_JUMP_EN defined: JAL 1101111 and JALR 1100111 decode with RegWrite=1, Jump=1.
//   JALR additionally sets ALUSrc=1 and uses rs1.
//  CTRL_JUMP_EN undefined: ex_jump_o tied 0; JAL/JALR treated as unknown (bubble + illegal_o).
// STRUCTURE
//  ctrl_pkg: opcode localparams, ctrl_bundle_t packed struct (alusrc..jump), ctrl_state_e enum.
//  Sub-module ctrl_decode: purely combinational opcode -> ctrl_bundle_t, uses_rs1/uses_rs2, illegal.
//  pipe_ctrl_unit: hazard logic, FSM, drain counter and ID/EX bundle register.
// TESTING
//  R-type opcode 0110011 in ID, no hazard
//   -> next cycle regwrite=1, aluop=10, alusrc=0, all other outputs 0.
//  ex_memread_i=1, ex_rd_i=5, ID is add with rs2=5
//   -> pc_write_o=ifid_write_o=0 for 1 cycle, bubble in EX; same with ex_rd_i=0 -> no stall.
//  Stall condition and branch_taken_i=1 in the same cycle
//   -> ifid_flush_o=1, pc_write_o=1, bubble in EX.
//  HALT in ID with DRAIN_DEPTH=3 -> PC frozen at once, halted_o=1 exactly 3 cycles later and sticky.
//   With branch_taken_i=1 in that cycle -> HALT discarded, state stays RUN.
//  Assert reset mid-DRAIN -> all outputs 0 immediately; after release, state RUN and halted_o stays 0.
//  Opcode 1101111: macro off -> illegal_o 1-cycle pulse, bubble; macro on -> ex_jump_o=1, ex_regwrite_o=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Purpose : shared opcode constants, control bundle and FSM state type for the pipeline control unit.
// Latency : n/a (type and constant definitions only).
// Backpressure: n/a.
package ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_HALT = 7'b1110101;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Field order matches the ex_*_o outputs of pipe_ctrl_unit.
  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Purpose : combinational RV32I opcode decoder -> control bundle, operand usage, halt/illegal flags.
// Latency : 0 cycles (purely combinational).
// Backpressure: none; the caller decides whether the decoded bundle is used.
// Ports   : opcode_i -> ctrl_o, uses_rs1_o, uses_rs2_o, is_halt_o, illegal_o.
// Option  : CTRL_JUMP_EN adds JAL/JALR decoding; otherwise they decode as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output ctrl_bundle_t ctrl_o,
  output logic         uses_rs1_o,
  output logic         uses_rs2_o,
  output logic         is_halt_o,
  output logic         illegal_o
);

  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    is_halt_o  = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_R: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = 2'b10;
        uses_rs1_o      = 1'b1;
        uses_rs2_o      = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memread  = 1'b1;
        uses_rs1_o      = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        uses_rs1_o      = 1'b1;
        uses_rs2_o      = 1'b1;
      end
      OP_BR: begin
        ctrl_o.aluop  = 2'b01;
        ctrl_o.branch = 1'b1;
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = 2'b10;
        uses_rs1_o      = 1'b1;
      end
      // HALT carries no control of its own; the FSM in the top reacts to it.
      OP_HALT: is_halt_o = 1'b1;
`ifdef CTRL_JUMP_EN
      OP_JAL: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.jump     = 1'b1;
      end
      OP_JALR: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        uses_rs1_o      = 1'b1;
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Purpose : ID-stage control for the 5-stage RV32I pipe: decode, load-use stall, branch flush, HALT drain.
// Latency : control bundle registered into ID/EX, visible one cycle after decode; PC/IF-ID enables are comb.
// Backpressure: load-use freezes PC and IF/ID for one cycle; HALT freezes them permanently until reset.
// Ports   : clk, reset (async, active-high); opcode_i/rs1_i/rs2_i from IF/ID; ex_rd_i/ex_memread_i and
//           branch_taken_i from EX; ex_*_o registered bundle; pc_write_o/ifid_write_o/ifid_flush_o comb;
//           illegal_o registered pulse; halted_o sticky.
// Option  : CTRL_JUMP_EN enables JAL/JALR decoding (ex_jump_o), handled inside ctrl_decode.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  branch_taken_i,
  output logic                  ex_alusrc_o,
  output logic                  ex_memtoreg_o,
  output logic                  ex_regwrite_o,
  output logic                  ex_memread_o,
  output logic                  ex_memwrite_o,
  output logic [1:0]            ex_aluop_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  illegal_o,
  output logic                  halted_o
);

  localparam int CNT_W = $clog2(DRAIN_DEPTH + 1);

  ctrl_bundle_t dec_ctrl;
  logic         dec_uses_rs1;
  logic         dec_uses_rs2;
  logic         dec_halt;
  logic         dec_illegal;

  ctrl_decode u_decode (
    .opcode_i   (opcode_i),
    .ctrl_o     (dec_ctrl),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2),
    .is_halt_o  (dec_halt),
    .illegal_o  (dec_illegal)
  );

  ctrl_state_e  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctrl_bundle_t ex_ctrl, ex_ctrl_nxt;
  logic         illegal_q, illegal_nxt;
  logic         pc_write, ifid_write, ifid_flush;
  logic         load_use;

  // x0 is never a real dependency, so a load targeting it cannot cause a stall.
  assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                    ((dec_uses_rs1 && (ex_rd_i == rs1_i)) ||
                     (dec_uses_rs2 && (ex_rd_i == rs2_i)));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ex_ctrl_nxt = CTRL_BUBBLE;
    illegal_nxt = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    case (state)
      ST_RUN: begin
        if (branch_taken_i) begin
          // Redirect wins over everything: whatever sits in ID (even HALT) is wrong-path.
          ifid_flush = 1'b1;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end else if (dec_halt) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_DEPTH - 1);
        end else if (!load_use) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ex_ctrl_nxt = dec_ctrl;
          illegal_nxt = dec_illegal;
        end
      end
      // Nothing older than the HALT can still redirect, so branch_taken_i is not looked at here.
      ST_DRAIN: begin
        if (cnt == '0) state_nxt = ST_HALTED;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      ex_ctrl   <= CTRL_BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ex_ctrl   <= ex_ctrl_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  // Enables are forced low while reset is held so the front end stays put.
  assign pc_write_o    = pc_write   & ~reset;
  assign ifid_write_o  = ifid_write & ~reset;
  assign ifid_flush_o  = ifid_flush & ~reset;

  assign ex_alusrc_o   = ex_ctrl.alusrc;
  assign ex_memtoreg_o = ex_ctrl.memtoreg;
  assign ex_regwrite_o = ex_ctrl.regwrite;
  assign ex_memread_o  = ex_ctrl.memread;
  assign ex_memwrite_o = ex_ctrl.memwrite;
  assign ex_aluop_o    = ex_ctrl.aluop;
  assign ex_branch_o   = ex_ctrl.branch;
  assign ex_jump_o     = ex_ctrl.jump;
  assign illegal_o     = illegal_q;
  assign halted_o      = (state == ST_HALTED);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Purpose : self-checking bench for pipe_ctrl_unit: directed scenarios then randomized traffic.
// Latency : expected values per cycle are queued by the driver and consumed by a negedge monitor.
// Backpressure: n/a.
module tb_pipe_ctrl_unit;

  localparam int DEPTH = 3;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] IMM  = 7'b0010011;
  localparam logic [6:0] HALT = 7'b1110101;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode_i = '0;
  logic [4:0] rs1_i = '0, rs2_i = '0, ex_rd_i = '0;
  logic       ex_memread_i = 1'b0, branch_taken_i = 1'b0;
  logic       ex_alusrc_o, ex_memtoreg_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o;
  logic [1:0] ex_aluop_o;
  logic       ex_branch_o, ex_jump_o, pc_write_o, ifid_write_o, ifid_flush_o, illegal_o, halted_o;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .DRAIN_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i), .branch_taken_i(branch_taken_i),
    .ex_alusrc_o(ex_alusrc_o), .ex_memtoreg_o(ex_memtoreg_o), .ex_regwrite_o(ex_regwrite_o),
    .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o), .ex_aluop_o(ex_aluop_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o), .illegal_o(illegal_o),
    .halted_o(halted_o)
  );

  // regs = {alusrc,memtoreg,regwrite,memread,memwrite,aluop[1:0],branch,jump}
  // comb = {pc_write,ifid_write,ifid_flush}
  typedef struct packed {
    logic [8:0] regs;
    logic       ill;
    logic       halted;
    logic [2:0] comb;
    logic [15:0] cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Model state: bundle/illegal now in EX and for the next edge; drain countdown
  // in cycles (-1 running, >0 draining, 0 halted).
  logic [8:0] m_regs = '0, n_regs = '0;
  logic       m_ill = 1'b0, n_ill = 1'b0;
  int         m_left = -1, n_left = -1;

  // Opcode table straight from the decode rules.
  task automatic decode(input logic [6:0] op, output logic [8:0] regs,
                        output logic rd1, output logic rd2, output logic unk);
    regs = '0; rd1 = 1'b0; rd2 = 1'b0; unk = 1'b0;
    case (op)
      R:    begin regs = {1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,1'b0,1'b0}; rd1 = 1; rd2 = 1; end
      LW:   begin regs = {1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0}; rd1 = 1; end
      SW:   begin regs = {1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0}; rd1 = 1; rd2 = 1; end
      BR:   begin regs = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0}; rd1 = 1; rd2 = 1; end
      IMM:  begin regs = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b10,1'b0,1'b0}; rd1 = 1; end
      HALT: regs = '0;
`ifdef CTRL_JUMP_EN
      JAL:  regs = {1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b1};
      JALR: begin regs = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b1}; rd1 = 1; end
`endif
      default: unk = 1'b1;
    endcase
  endtask

  // One clock cycle: present inputs, queue what the DUT must show this cycle,
  // then move past the next rising edge.
  task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] erd, input logic emr, input logic br);
    logic [8:0] d;
    logic       rd1, rd2, unk, hz;
    logic [2:0] comb;
    exp_t       e;
    m_regs = n_regs; m_ill = n_ill; m_left = n_left;
    opcode_i = op; rs1_i = r1; rs2_i = r2; ex_rd_i = erd; ex_memread_i = emr; branch_taken_i = br;
    decode(op, d, rd1, rd2, unk);
    hz = emr && erd != 0 && ((rd1 && erd == r1) || (rd2 && erd == r2));
    n_regs = '0; n_ill = 1'b0;
    if (m_left >= 0) begin
      comb = 3'b000;
      n_left = (m_left > 0) ? m_left - 1 : 0;
    end else if (br) begin
      comb = 3'b111;
    end else if (op == HALT) begin
      comb = 3'b000;
      n_left = DEPTH;
    end else if (hz) begin
      comb = 3'b000;
    end else begin
      comb = 3'b110;
      n_regs = d;
      n_ill = unk;
    end
    e.regs = m_regs; e.ill = m_ill; e.halted = (m_left == 0); e.comb = comb; e.cyc = 16'(cyc);
    q.push_back(e);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    m_regs = '0; n_regs = '0; m_ill = 1'b0; n_ill = 1'b0; m_left = -1; n_left = -1;
    e = '0; e.cyc = 16'(cyc);
    q.push_back(e);
    cyc++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check(input string name, input int c, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, c, got, want);
    end
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("bundle", int'(e.cyc), {ex_alusrc_o, ex_memtoreg_o, ex_regwrite_o, ex_memread_o,
              ex_memwrite_o, ex_aluop_o, ex_branch_o, ex_jump_o}, e.regs);
        check("enables", int'(e.cyc), {6'b0, pc_write_o, ifid_write_o, ifid_flush_o}, {6'b0, e.comb});
        check("illegal", int'(e.cyc), {8'b0, illegal_o}, {8'b0, e.ill});
        check("halted", int'(e.cyc), {8'b0, halted_o}, {8'b0, e.halted});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] op;
    @(posedge clk); #1;
    do_reset();
    // Plain decode with no hazard.
    step(R, 1, 2, 0, 0, 0);
    step(IMM, 3, 0, 0, 0, 0);
    step(SW, 1, 2, 0, 0, 0);
    // Load-use on rs2, then the bubble lets it through; x0 destination never stalls.
    step(R, 1, 5, 5, 1, 0);
    step(R, 1, 5, 5, 0, 0);
    step(R, 1, 0, 0, 1, 0);
    // Stall and taken branch together: flush wins.
    step(R, 5, 1, 5, 1, 1);
    // Wrong-path HALT is dropped.
    step(HALT, 0, 0, 0, 0, 1);
    step(BR, 1, 2, 0, 0, 0);
    // Real HALT: freeze, drain, then sticky halted (branch ignored while frozen).
    step(HALT, 0, 0, 0, 0, 0);
    step(R, 1, 2, 0, 0, 1);
    repeat (7) step(LW, 1, 2, 0, 0, 0);
    // Reset in the middle of a drain: no halted afterwards.
    do_reset();
    step(HALT, 0, 0, 0, 0, 0);
    step(R, 1, 2, 0, 0, 0);
    do_reset();
    repeat (5) step(R, 1, 2, 0, 0, 0);
    // Jump opcodes and unknown opcodes.
    step(JAL, 1, 2, 0, 0, 0);
    step(JALR, 5, 0, 5, 1, 0);
    step(7'h7f, 0, 0, 0, 0, 0);
    step(R, 1, 2, 0, 0, 0);

    for (int i = 0; i < 900; i++) begin
      if (n_left >= 0 && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 9))
          0: op = R; 1: op = LW; 2: op = SW; 3: op = BR; 4: op = IMM;
          5: op = JAL; 6: op = JALR; 7: op = 7'($urandom_range(0, 127));
          default: op = R;
        endcase
        if ($urandom_range(0, 29) == 0) op = HALT;
        step(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      end
    end

    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue leftover=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
